// File: rtl/page_map_ctl.sv
// ---------------------------------------------------------------------------
// page_map_ctl
//
// Command sequencer in front of the page_map block. The host queues map-edit
// commands (NOP / ADD / REMOVE / CLEAR) through a valid/ready handshake into a
// small FIFO. The sequencer pops one command at a time, drives page_map with a
// single-cycle op pulse, follows page_map's valid low/high busy window and then
// pulses done. CLEAR becomes two removals, (0,255) then (255,1), because a
// single 8-bit size cannot cover all 256 pages.
//
// Parameters
//   DEPTH    command FIFO entries, power of two in 2..16
//   TIMEOUT  cycles allowed in each wait state before err is flagged
//
// Optional feature
//   PAGE_MAP_CTL_TIMEOUT_EN  when defined, a watchdog runs in WAIT_LOW and
//   WAIT_HIGH; on expiry err is set, done is pulsed and the command (including
//   any remaining CLEAR phase) is abandoned. When undefined no counter is built,
//   err is tied low and the sequencer waits indefinitely.
//
// Ports
//   clk200     in   main clock
//   a8_rst     in   synchronous reset, active-high
//   cmd_valid  in   host command present
//   cmd_ready  out  command will be accepted this cycle
//   cmd_kind   in   [1:0] 0 = NOP, 1 = ADD, 2 = REMOVE, 3 = CLEAR
//   cmd_from   in   [7:0] first page
//   cmd_size   in   [7:0] number of pages
//   pm_op      out  [1:0] op to page_map, OP_NONE except for one-cycle pulses
//   pm_from    out  [7:0] from to page_map (registered, held between issues)
//   pm_size    out  [7:0] size to page_map (registered, held between issues)
//   pm_valid   in   valid from page_map (low while it is working)
//   busy       out  FIFO non-empty or sequencer not idle
//   done       out  one-cycle pulse when a host command completes
//   err        out  sticky timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module page_map_ctl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic       clk200,
  input  logic       a8_rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_kind,
  input  logic [7:0] cmd_from,
  input  logic [7:0] cmd_size,
  output logic [1:0] pm_op,
  output logic [7:0] pm_from,
  output logic [7:0] pm_size,
  input  logic       pm_valid,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // page_map op encodings (must match the OP_* values page_map decodes)
  localparam logic [1:0] OP_NONE   = 2'd0;
  localparam logic [1:0] OP_ADD    = 2'd1;
  localparam logic [1:0] OP_REMOVE = 2'd2;

  // Host command kinds
  localparam logic [1:0] KIND_NOP    = 2'd0;
  localparam logic [1:0] KIND_ADD    = 2'd1;
  localparam logic [1:0] KIND_REMOVE = 2'd2;
  localparam logic [1:0] KIND_CLEAR  = 2'd3;

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_LOW,
    WAIT_HIGH,
    NEXT
  } state_t;

  state_t state;

  // ------------------------------------------------------------------------
  // Command FIFO
  // ------------------------------------------------------------------------
  logic [1:0]    mem_kind [DEPTH];
  logic [7:0]    mem_from [DEPTH];
  logic [7:0]    mem_size [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  logic [1:0]    head_kind;
  logic [7:0]    head_from;
  logic [7:0]    head_size;

  assign wr_addr = wr_ptr[AW-1:0];
  assign rd_addr = rd_ptr[AW-1:0];

  // Pointers carry one extra wrap bit: equal addresses with differing wrap
  // bits means full, identical pointers means empty.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_addr == rd_addr);
  assign empty = (wr_ptr == rd_ptr);

  // The head is taken only when page_map reports it is ready for a new op.
  assign pop = (state == IDLE) && !empty && pm_valid;

  // A pop in the same cycle frees a slot, so a full FIFO may still take a
  // command then; otherwise a full FIFO refuses it.
  assign cmd_ready = !full || pop;
  assign push      = cmd_valid && cmd_ready;

  assign head_kind = mem_kind[rd_addr];
  assign head_from = mem_from[rd_addr];
  assign head_size = mem_size[rd_addr];

  assign busy = !empty || (state != IDLE);

  // FIFO storage needs no reset; only the pointers define its contents.
  always_ff @(posedge clk200) begin
    if (push) begin
      mem_kind[wr_addr] <= cmd_kind;
      mem_from[wr_addr] <= cmd_from;
      mem_size[wr_addr] <= cmd_size;
    end
  end

  // Pointer update; a simultaneous push and pop simply advance both.
  always_ff @(posedge clk200) begin
    if (a8_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // ------------------------------------------------------------------------
  // Op selection: maps a command kind and CLEAR phase onto the page_map op,
  // from and size, packed as {op, from, size}.
  // ------------------------------------------------------------------------
  function automatic logic [17:0] op_for(input logic [1:0] k,
                                         input logic [7:0] f,
                                         input logic [7:0] s,
                                         input logic       ph);
    case (k)
      KIND_ADD:    op_for = {OP_ADD, f, s};
      KIND_REMOVE: op_for = {OP_REMOVE, f, s};
      KIND_CLEAR:  op_for = ph ? {OP_REMOVE, 8'd255, 8'd1}
                               : {OP_REMOVE, 8'd0, 8'd255};
      default:     op_for = {OP_NONE, 8'd0, 8'd0};
    endcase
  endfunction

  // ------------------------------------------------------------------------
  // Wait-state watchdog
  // ------------------------------------------------------------------------
  logic timed_out;

`ifdef PAGE_MAP_CTL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;
  logic          waiting;
  logic          err_q;

  // Still waiting means in a wait state whose exit condition is not met yet.
  assign waiting   = ((state == WAIT_LOW)  &&  pm_valid) ||
                     ((state == WAIT_HIGH) && !pm_valid);
  assign timed_out = waiting && (wait_cnt == CW'(TIMEOUT - 1));
  assign err       = err_q;

  // The count restarts from zero whenever a wait state is (re)entered,
  // because it is cleared in every cycle that is not a continued wait.
  always_ff @(posedge clk200) begin
    if (a8_rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (waiting && !timed_out) begin
        wait_cnt <= wait_cnt + CW'(1);
      end else begin
        wait_cnt <= '0;
      end
      if (timed_out) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout;

  // No watchdog in this build: waits are unbounded and err never rises.
  assign timed_out      = 1'b0;
  assign err            = 1'b0;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  // ------------------------------------------------------------------------
  // Sequencer. pm_op, pm_from and pm_size are loaded on the transition into
  // ISSUE so the op pulse coincides with the ISSUE cycle; done is raised on
  // the transition into the completing cycle so it is a registered pulse.
  // ------------------------------------------------------------------------
  logic [1:0] work_kind;
  logic [7:0] work_from;
  logic [7:0] work_size;
  logic       work_phase;

  always_ff @(posedge clk200) begin
    if (a8_rst) begin
      state      <= IDLE;
      work_kind  <= KIND_NOP;
      work_from  <= 8'd0;
      work_size  <= 8'd0;
      work_phase <= 1'b0;
      pm_op      <= OP_NONE;
      pm_from    <= 8'd0;
      pm_size    <= 8'd0;
      done       <= 1'b0;
    end else begin
      pm_op <= OP_NONE;
      done  <= 1'b0;

      case (state)
        IDLE: begin
          if (pop) begin
            work_kind  <= head_kind;
            work_from  <= head_from;
            work_size  <= head_size;
            work_phase <= 1'b0;
            // Commands that touch no pages complete without involving page_map.
            if ((head_kind == KIND_NOP) ||
                ((head_kind != KIND_CLEAR) && (head_size == 8'd0))) begin
              done <= 1'b1;
            end else begin
              state                     <= ISSUE;
              {pm_op, pm_from, pm_size} <= op_for(head_kind, head_from,
                                                  head_size, 1'b0);
            end
          end
        end

        ISSUE: begin
          state <= WAIT_LOW;
        end

        WAIT_LOW: begin
          if (!pm_valid) begin
            state <= WAIT_HIGH;
          end else if (timed_out) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end

        WAIT_HIGH: begin
          if (pm_valid) begin
            state <= NEXT;
            // The first CLEAR phase is not a completion; phase 1 still follows.
            if (!((work_kind == KIND_CLEAR) && !work_phase)) begin
              done <= 1'b1;
            end
          end else if (timed_out) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end

        NEXT: begin
          if ((work_kind == KIND_CLEAR) && !work_phase) begin
            work_phase                <= 1'b1;
            state                     <= ISSUE;
            {pm_op, pm_from, pm_size} <= op_for(work_kind, work_from,
                                                work_size, 1'b1);
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_page_map_ctl.sv
// ---------------------------------------------------------------------------
// tb_page_map_ctl
//
// Self-checking bench for page_map_ctl. A behavioural page_map model answers
// each op (valid low one cycle after the op, high again four cycles later) and
// keeps a 256-entry page map. Expected results come from a command-level
// reference: the list of page_map ops each host command should produce, the
// resulting page map, and the number of done pulses.
// Define PAGE_MAP_CTL_TIMEOUT_EN for both files to exercise the watchdog.
// ---------------------------------------------------------------------------
module tb_page_map_ctl;

  localparam logic [1:0] OP_NONE   = 2'd0;
  localparam logic [1:0] OP_ADD    = 2'd1;
  localparam logic [1:0] OP_REMOVE = 2'd2;

  localparam logic [1:0] K_NOP = 2'd0;
  localparam logic [1:0] K_ADD = 2'd1;
  localparam logic [1:0] K_REM = 2'd2;
  localparam logic [1:0] K_CLR = 2'd3;

  logic       clk200    = 1'b0;
  logic       a8_rst    = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_kind  = 2'd0;
  logic [7:0] cmd_from  = 8'd0;
  logic [7:0] cmd_size  = 8'd0;
  logic       cmd_ready;
  logic [1:0] pm_op;
  logic [7:0] pm_from;
  logic [7:0] pm_size;
  logic       pm_valid;
  logic       busy;
  logic       done;
  logic       err;

  int errors = 0;
  int checks = 0;

  always #5 clk200 = ~clk200;

  page_map_ctl #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk200    (clk200),
    .a8_rst    (a8_rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_kind  (cmd_kind),
    .cmd_from  (cmd_from),
    .cmd_size  (cmd_size),
    .pm_op     (pm_op),
    .pm_from   (pm_from),
    .pm_size   (pm_size),
    .pm_valid  (pm_valid),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Cycle index: value k holds from posedge k to posedge k+1.
  int cyc = 0;
  always @(posedge clk200) cyc <= cyc + 1;

  // page_map model; stall forces valid low, hang makes it ignore ops.
  logic        model_valid = 1'b1;
  int          lat         = 0;
  bit          stall       = 1'b0;
  bit          hang        = 1'b0;
  bit          model_map [256];
  logic [17:0] op_log [$];
  int          op_cyc [$];

  assign pm_valid = model_valid && !stall;

  always @(posedge clk200) begin
    if (a8_rst) begin
      model_valid <= 1'b1;
      lat         <= 0;
    end else if (pm_op != OP_NONE) begin
      op_log.push_back({pm_op, pm_from, pm_size});
      op_cyc.push_back(cyc);
      if (!hang) begin
        model_valid <= 1'b0;
        lat         <= 4;
        for (int i = 0; i < 256; i++) begin
          if (i >= int'(pm_from) && i < int'(pm_from) + int'(pm_size)) begin
            model_map[i] <= (pm_op == OP_ADD);
          end
        end
      end
    end else if (lat > 0) begin
      lat <= lat - 1;
      if (lat == 1) model_valid <= 1'b1;
    end
  end

  // done monitor
  int done_cnt  = 0;
  int last_done = -1;
  always @(negedge clk200) begin
    if (done === 1'b1) begin
      done_cnt  = done_cnt + 1;
      last_done = cyc;
    end
  end

  // Command-level reference
  logic [17:0] exp_ops [$];
  bit          ref_map [256];
  int          exp_done = 0;

  function automatic void ref_cmd(input logic [1:0] k, input logic [7:0] f,
                                  input logic [7:0] s);
    exp_done++;
    if (k == K_CLR) begin
      exp_ops.push_back({OP_REMOVE, 8'd0, 8'd255});
      exp_ops.push_back({OP_REMOVE, 8'd255, 8'd1});
      for (int i = 0; i < 256; i++) ref_map[i] = 1'b0;
    end else if (k != K_NOP && s != 8'd0) begin
      exp_ops.push_back({(k == K_ADD) ? OP_ADD : OP_REMOVE, f, s});
      for (int i = int'(f); i < int'(f) + int'(s) && i < 256; i++) begin
        ref_map[i] = (k == K_ADD);
      end
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step_cycle();
    @(negedge clk200);
    #1;
  endtask

  // Offers one command for up to max_wait cycles; reports acceptance cycle.
  task automatic applyStimulus(input logic [1:0] k, input logic [7:0] f,
                               input logic [7:0] s, input int max_wait,
                               output bit accepted, output int push_cyc);
    accepted  = 1'b0;
    push_cyc  = -1;
    cmd_kind  = k;
    cmd_from  = f;
    cmd_size  = s;
    cmd_valid = 1'b1;
    for (int n = 0; n < max_wait; n++) begin
      if (cmd_ready === 1'b1) begin
        accepted = 1'b1;
        push_cyc = cyc;
      end
      step_cycle();
      if (accepted) break;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (busy !== 1'b0 && n < max_cycles) begin
      step_cycle();
      n++;
    end
    checkOutput("drain_to_idle", {31'd0, busy}, 32'd0);
    step_cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_pm_op"},     {30'd0, pm_op},     32'd0);
    checkOutput({tag, "_pm_from"},   {24'd0, pm_from},   32'd0);
    checkOutput({tag, "_pm_size"},   {24'd0, pm_size},   32'd0);
    checkOutput({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    checkOutput({tag, "_busy"},      {31'd0, busy},      32'd0);
    checkOutput({tag, "_done"},      {31'd0, done},      32'd0);
    checkOutput({tag, "_err"},       {31'd0, err},       32'd0);
  endtask

  task automatic compare_results(input string tag);
    int bad = 0;
    checkOutput({tag, "_op_count"}, op_log.size(), exp_ops.size());
    for (int i = 0; i < op_log.size() && i < exp_ops.size(); i++) begin
      checkOutput({tag, "_op"}, {14'd0, op_log[i]}, {14'd0, exp_ops[i]});
    end
    for (int i = 0; i < 256; i++) if (model_map[i] != ref_map[i]) bad++;
    checkOutput({tag, "_map_diffs"}, bad, 0);
    checkOutput({tag, "_done_count"}, done_cnt, exp_done);
    op_log.delete();
    op_cyc.delete();
    exp_ops.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit   acc;
    int   pc;
    int   n;
    int   ones;
    logic [1:0] k;
    logic [7:0] f;
    logic [7:0] s;

    // Reset
    step_cycle();
    step_cycle();
    check_reset_outputs("reset");
    a8_rst = 1'b0;
    step_cycle();

    // Single ADD: one pulse, done 7 cycles after the pop
    $display("[TB] ADD 8/4");
    applyStimulus(K_ADD, 8'd8, 8'd4, 4, acc, pc);
    checkOutput("add_accepted", {31'd0, acc}, 32'd1);
    ref_cmd(K_ADD, 8'd8, 8'd4);
    wait_idle(50);
    checkOutput("add_op_cycle", (op_cyc.size() > 0) ? op_cyc[0] : -1, pc + 2);
    checkOutput("add_done_latency", last_done - (pc + 1), 7);
    checkOutput("add_map_8_11",
                {28'd0, model_map[11], model_map[10], model_map[9], model_map[8]},
                32'hF);
    compare_results("add");

    // NOP and zero-size ADD: done one cycle after the pop, no op
    $display("[TB] NOP and empty ADD");
    applyStimulus(K_NOP, 8'd3, 8'd3, 4, acc, pc);
    ref_cmd(K_NOP, 8'd3, 8'd3);
    wait_idle(20);
    checkOutput("nop_done_latency", last_done - (pc + 1), 1);
    applyStimulus(K_ADD, 8'd40, 8'd0, 4, acc, pc);
    ref_cmd(K_ADD, 8'd40, 8'd0);
    wait_idle(20);
    checkOutput("add0_done_latency", last_done - (pc + 1), 1);
    compare_results("empty");

    // CLEAR after ADDs, one of them overflowing page 255
    $display("[TB] CLEAR after ADDs");
    applyStimulus(K_ADD, 8'd20, 8'd10, 40, acc, pc);
    ref_cmd(K_ADD, 8'd20, 8'd10);
    applyStimulus(K_ADD, 8'd250, 8'd10, 40, acc, pc);
    ref_cmd(K_ADD, 8'd250, 8'd10);
    applyStimulus(K_CLR, 8'd77, 8'd5, 40, acc, pc);
    ref_cmd(K_CLR, 8'd77, 8'd5);
    wait_idle(100);
    ones = 0;
    for (int i = 0; i < 256; i++) if (model_map[i]) ones++;
    checkOutput("clear_map_empty", ones, 0);
    compare_results("clear");

    // FIFO full while the sequencer is held off by pm_valid low
    $display("[TB] FIFO full");
    stall = 1'b1;
    step_cycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(K_ADD, 8'(10 * i), 8'd2, 1, acc, pc);
      checkOutput("full_push_accepted", {31'd0, acc}, 32'd1);
      ref_cmd(K_ADD, 8'(10 * i), 8'd2);
    end
    checkOutput("full_ready_low", {31'd0, cmd_ready}, 32'd0);
    applyStimulus(K_ADD, 8'd100, 8'd9, 2, acc, pc);
    checkOutput("full_fifth_ignored", {31'd0, acc}, 32'd0);
    stall = 1'b0;
    #1;
    checkOutput("full_ready_with_pop", {31'd0, cmd_ready}, 32'd1);
    applyStimulus(K_ADD, 8'd200, 8'd3, 1, acc, pc);
    checkOutput("full_push_with_pop", {31'd0, acc}, 32'd1);
    ref_cmd(K_ADD, 8'd200, 8'd3);
    wait_idle(200);
    compare_results("full");

    // Randomized command stream
    $display("[TB] random commands");
    for (int i = 0; i < 16; i++) begin
      n = $urandom_range(0, 9);
      k = (n < 1) ? K_NOP : (n < 5) ? K_ADD : (n < 9) ? K_REM : K_CLR;
      f = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 40));
      applyStimulus(k, f, s, 100, acc, pc);
      checkOutput("rand_accepted", {31'd0, acc}, 32'd1);
      if (acc) ref_cmd(k, f, s);
      repeat ($urandom_range(0, 3)) step_cycle();
    end
    wait_idle(1000);
    compare_results("random");

    // Reset during WAIT_HIGH of a CLEAR
    $display("[TB] reset during CLEAR");
    applyStimulus(K_CLR, 8'd0, 8'd0, 4, acc, pc);
    n = 0;
    while (op_log.size() == 0 && n < 20) begin
      step_cycle();
      n++;
    end
    checkOutput("rst_first_op_seen", op_log.size(), 1);
    step_cycle();
    step_cycle();
    a8_rst = 1'b1;
    step_cycle();
    check_reset_outputs("midrst");
    a8_rst = 1'b0;
    repeat (30) step_cycle();
    checkOutput("rst_no_second_phase", op_log.size(), 1);
    if (op_log.size() > 0) begin
      checkOutput("rst_first_phase", {14'd0, op_log[0]},
                  {14'd0, OP_REMOVE, 8'd0, 8'd255});
    end
    checkOutput("rst_no_done", done_cnt, exp_done);
    for (int i = 0; i < 255; i++) ref_map[i] = 1'b0;
    op_log.delete();
    op_cyc.delete();

`ifdef PAGE_MAP_CTL_TIMEOUT_EN
    // page_map ignores the op: 16 cycles in WAIT_LOW, then err and done
    $display("[TB] timeout");
    hang = 1'b1;
    applyStimulus(K_ADD, 8'd1, 8'd1, 4, acc, pc);
    applyStimulus(K_ADD, 8'd2, 8'd2, 4, acc, pc);
    n = 0;
    while (done_cnt == exp_done && n < 40) begin
      step_cycle();
      n++;
    end
    hang = 1'b0;
    checkOutput("to_done_latency",
                last_done - ((op_cyc.size() > 0) ? op_cyc[0] : 0), 17);
    checkOutput("to_err_set", {31'd0, err}, 32'd1);
    exp_done++;
    wait_idle(100);
    checkOutput("to_next_issued", op_log.size(), 2);
    if (op_log.size() > 1) begin
      checkOutput("to_next_op", {14'd0, op_log[1]}, {14'd0, OP_ADD, 8'd2, 8'd2});
    end
    exp_done++;
    checkOutput("to_done_count", done_cnt, exp_done);
`else
    checkOutput("err_tied_low", {31'd0, err}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
